// File: rtl/sp1_ope_arb.sv
// Arbitrated front end for the shared add/incr/decr datapath: grant, latch, execute, ack.
// Define SP1_OPE_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed highest priority.
module sp1_ope_arb #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [DW*NREQ-1:0]   a,
    input  logic [DW*NREQ-1:0]   b,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        y,
    output logic                 c,
    output logic                 busy,
    output logic [IW-1:0]        gnt_id
);

    localparam int unsigned OPW = 2;

    localparam logic [OPW-1:0] OP_ADD  = 2'b00;
    localparam logic [OPW-1:0] OP_INCR = 2'b01;
    localparam logic [OPW-1:0] OP_DECR = 2'b10;

    typedef enum logic [1:0] {IDLE, LAT, EXE, ACK} state_t;

    state_t             state, state_d;
    logic [OPW-1:0]     op_l;
    logic [DW-1:0]      a_l, b_l;
    logic               win_found;
    logic [IW-1:0]      win_id, cand;
    logic [OPW-1:0]     win_op;
    logic [DW-1:0]      win_a, win_b;
    logic [DW:0]        add_r, inc_r, dec_r;
    logic [DW-1:0]      res_y;
    logic               res_c;

`ifdef SP1_OPE_ARB_RR_EN
    logic [IW-1:0]      ptr;
`endif

    // Winner search: first requester at or after the start point
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef SP1_OPE_ARB_RR_EN
            cand = IW'((32'(ptr) + i) % NREQ);
`else
            cand = IW'(i);
`endif
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Route the winner's opcode and operands to the latch
    always_comb begin
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (win_id == IW'(j)) begin
                win_op = op[OPW*j +: OPW];
                win_a  = a[DW*j +: DW];
                win_b  = b[DW*j +: DW];
            end
        end
    end

    // Shared ope units fed from the latched operands
    assign add_r = {1'b0, a_l} + {1'b0, b_l};
    assign inc_r = {1'b0, a_l} + (DW+1)'(1);
    assign dec_r = {1'b0, a_l} - (DW+1)'(1);

    always_comb begin
        res_y = a_l;
        res_c = 1'b0;
        case (op_l)
            OP_ADD:  begin res_y = add_r[DW-1:0]; res_c = add_r[DW]; end
            OP_INCR: begin res_y = inc_r[DW-1:0]; res_c = inc_r[DW]; end
            OP_DECR: begin res_y = dec_r[DW-1:0]; res_c = dec_r[DW]; end
            default: begin res_y = a_l;           res_c = 1'b0;      end
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (win_found) state_d = LAT;
            LAT:     state_d = EXE;
            EXE:     state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack    <= '0;
            y      <= '0;
            c      <= 1'b0;
            busy   <= 1'b0;
            gnt_id <= '0;
            op_l   <= '0;
            a_l    <= '0;
            b_l    <= '0;
        end else begin
            ack  <= '0;
            busy <= (state_d == LAT) || (state_d == EXE);
            if (state == IDLE && win_found) begin
                gnt_id <= win_id;
                op_l   <= win_op;
                a_l    <= win_a;
                b_l    <= win_b;
            end
            if (state == EXE) begin
                y   <= res_y;
                c   <= res_c;
                ack <= NREQ'(1) << gnt_id;
            end
        end
    end

`ifdef SP1_OPE_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst)                           ptr <= '0;
        else if (state == IDLE && win_found) ptr <= IW'((32'(win_id) + 1) % NREQ);
    end
`endif

endmodule
